// File: rtl/cfg_fv_pkg.sv
// Shared types and constants for the flash/VPD config request sequencer.
package cfg_fv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLSH = 2'd1,
        VPD  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic TGT_FLASH = 1'b0;
    localparam logic TGT_VPD   = 1'b1;

    localparam int unsigned ERR_TO   = 0;
    localparam int unsigned ERR_RESP = 1;
    localparam int unsigned ERR_ADDR = 2;

    localparam logic [31:0] TO_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cfg_fv_timer.sv
// Access timeout counter: cleared on request accept, counts while enabled,
// saturates at TIMEOUT_CYCLES-1 and flags expiry in that cycle.
module cfg_fv_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;
    logic [TO_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (en && (count != LAST)) begin
            count_nxt = count + 1'b1;
        end
    end

    // expired is registered from the next count so it lines up with count==LAST
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/cfg_flash_vpd_seq.sv
// Routes single-cycle host config requests to the flash AXI-Lite or VPD port,
// holds the enable until done or timeout, and returns one response pulse.
module cfg_flash_vpd_seq
    import cfg_fv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_tgt,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_devsel,
    input  logic        req_expand_en,
    input  logic        req_expand_dir,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_err,
    output logic        late_done,
    output logic [1:0]  cfg_flsh_devsel,
    output logic [13:0] cfg_flsh_addr,
    output logic        cfg_flsh_wren,
    output logic        cfg_flsh_rden,
    output logic [31:0] cfg_flsh_wdata,
    output logic        cfg_flsh_expand_enable,
    output logic        cfg_flsh_expand_dir,
    input  logic [31:0] flsh_cfg_rdata,
    input  logic        flsh_cfg_done,
    input  logic [1:0]  flsh_cfg_bresp,
    input  logic [1:0]  flsh_cfg_rresp,
    output logic [14:0] cfg_vpd_addr,
    output logic        cfg_vpd_wren,
    output logic        cfg_vpd_rden,
    output logic [31:0] cfg_vpd_wdata,
    input  logic [31:0] vpd_cfg_rdata,
    input  logic        vpd_cfg_done,
    input  logic        vpd_err_unimplemented_addr
);

    state_e      state, state_nxt;
    logic        wr_q, wr_nxt;
    logic        tmr_clear, tmr_en, tmr_expired;
    logic        req_ready_nxt, rsp_valid_nxt;
    logic [31:0] rsp_rdata_nxt;
    logic [2:0]  rsp_err_nxt;
    logic [1:0]  flsh_devsel_nxt;
    logic [13:0] flsh_addr_nxt;
    logic        flsh_wren_nxt, flsh_rden_nxt;
    logic [31:0] flsh_wdata_nxt;
    logic        flsh_exp_en_nxt, flsh_exp_dir_nxt;
    logic [14:0] vpd_addr_nxt;
    logic        vpd_wren_nxt, vpd_rden_nxt;
    logic [31:0] vpd_wdata_nxt;

    cfg_fv_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next state and next registered outputs; enables default low so they drop on exit.
    always_comb begin
        state_nxt        = state;
        wr_nxt           = wr_q;
        tmr_clear        = 1'b0;
        tmr_en           = 1'b0;
        rsp_valid_nxt    = 1'b0;
        rsp_rdata_nxt    = rsp_rdata;
        rsp_err_nxt      = rsp_err;
        flsh_devsel_nxt  = cfg_flsh_devsel;
        flsh_addr_nxt    = cfg_flsh_addr;
        flsh_wdata_nxt   = cfg_flsh_wdata;
        flsh_exp_en_nxt  = cfg_flsh_expand_enable;
        flsh_exp_dir_nxt = cfg_flsh_expand_dir;
        flsh_wren_nxt    = 1'b0;
        flsh_rden_nxt    = 1'b0;
        vpd_addr_nxt     = cfg_vpd_addr;
        vpd_wdata_nxt    = cfg_vpd_wdata;
        vpd_wren_nxt     = 1'b0;
        vpd_rden_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    wr_nxt = req_wr;
                    if (req_tgt == TGT_FLASH && req_addr[14]) begin
                        state_nxt             = RESP;
                        rsp_valid_nxt         = 1'b1;
                        rsp_rdata_nxt         = '0;
                        rsp_err_nxt           = '0;
                        rsp_err_nxt[ERR_ADDR] = 1'b1;
                    end else if (req_tgt == TGT_FLASH) begin
                        state_nxt        = FLSH;
                        tmr_clear        = 1'b1;
                        flsh_devsel_nxt  = req_devsel;
                        flsh_addr_nxt    = req_addr[13:0];
                        flsh_wdata_nxt   = req_wdata;
                        flsh_exp_en_nxt  = req_expand_en;
                        flsh_exp_dir_nxt = req_expand_dir;
                        flsh_wren_nxt    = req_wr;
                        flsh_rden_nxt    = !req_wr;
                    end else begin
                        state_nxt     = VPD;
                        tmr_clear     = 1'b1;
                        vpd_addr_nxt  = req_addr;
                        vpd_wdata_nxt = req_wdata;
                        vpd_wren_nxt  = req_wr;
                        vpd_rden_nxt  = !req_wr;
                    end
                end
            end
            FLSH: begin
                tmr_en = 1'b1;
                if (flsh_cfg_done) begin
                    state_nxt             = RESP;
                    rsp_valid_nxt         = 1'b1;
                    rsp_rdata_nxt         = wr_q ? 32'h0 : flsh_cfg_rdata;
                    rsp_err_nxt           = '0;
                    rsp_err_nxt[ERR_RESP] = wr_q ? (flsh_cfg_bresp != 2'b00)
                                                 : (flsh_cfg_rresp != 2'b00);
                end else if (tmr_expired) begin
                    state_nxt           = RESP;
                    rsp_valid_nxt       = 1'b1;
                    rsp_rdata_nxt       = TO_RDATA;
                    rsp_err_nxt         = '0;
                    rsp_err_nxt[ERR_TO] = 1'b1;
                end else begin
                    flsh_wren_nxt = wr_q;
                    flsh_rden_nxt = !wr_q;
                end
            end
            VPD: begin
                tmr_en = 1'b1;
                if (vpd_cfg_done) begin
                    state_nxt             = RESP;
                    rsp_valid_nxt         = 1'b1;
                    rsp_rdata_nxt         = wr_q ? 32'h0 : vpd_cfg_rdata;
                    rsp_err_nxt           = '0;
                    rsp_err_nxt[ERR_ADDR] = vpd_err_unimplemented_addr;
                end else if (tmr_expired) begin
                    state_nxt           = RESP;
                    rsp_valid_nxt       = 1'b1;
                    rsp_rdata_nxt       = TO_RDATA;
                    rsp_err_nxt         = '0;
                    rsp_err_nxt[ERR_TO] = 1'b1;
                end else begin
                    vpd_wren_nxt = wr_q;
                    vpd_rden_nxt = !wr_q;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            wr_q                   <= 1'b0;
            req_ready              <= 1'b1;
            rsp_valid              <= 1'b0;
            rsp_rdata              <= '0;
            rsp_err                <= '0;
            late_done              <= 1'b0;
            cfg_flsh_devsel        <= '0;
            cfg_flsh_addr          <= '0;
            cfg_flsh_wren          <= 1'b0;
            cfg_flsh_rden          <= 1'b0;
            cfg_flsh_wdata         <= '0;
            cfg_flsh_expand_enable <= 1'b0;
            cfg_flsh_expand_dir    <= 1'b0;
            cfg_vpd_addr           <= '0;
            cfg_vpd_wren           <= 1'b0;
            cfg_vpd_rden           <= 1'b0;
            cfg_vpd_wdata          <= '0;
        end else begin
            state                  <= state_nxt;
            wr_q                   <= wr_nxt;
            req_ready              <= req_ready_nxt;
            rsp_valid              <= rsp_valid_nxt;
            rsp_rdata              <= rsp_rdata_nxt;
            rsp_err                <= rsp_err_nxt;
            late_done              <= late_done
                                    | (flsh_cfg_done && (state != FLSH))
                                    | (vpd_cfg_done  && (state != VPD));
            cfg_flsh_devsel        <= flsh_devsel_nxt;
            cfg_flsh_addr          <= flsh_addr_nxt;
            cfg_flsh_wren          <= flsh_wren_nxt;
            cfg_flsh_rden          <= flsh_rden_nxt;
            cfg_flsh_wdata         <= flsh_wdata_nxt;
            cfg_flsh_expand_enable <= flsh_exp_en_nxt;
            cfg_flsh_expand_dir    <= flsh_exp_dir_nxt;
            cfg_vpd_addr           <= vpd_addr_nxt;
            cfg_vpd_wren           <= vpd_wren_nxt;
            cfg_vpd_rden           <= vpd_rden_nxt;
            cfg_vpd_wdata          <= vpd_wdata_nxt;
        end
    end

endmodule
